// File: rtl/frame_buffer_writer.sv
// -----------------------------------------------------------------------------
// frame_buffer_writer
//
// Avalon-MM burst write master feeding the HPS SDRAM frame buffer through the
// f2h_sdram0 port. Pixel words arrive on a valid/ready stream, are buffered in
// a small FIFO and written out as fixed-length bursts. Bursts are placed
// sequentially from the frame base and wrap back to it at the frame end.
// frame_start throws away any partial data and restarts at the frame base.
//
// Ports:
//   clock         system clock (clock_50 domain)
//   reset_n       asynchronous active-low reset
//   frame_start   one-cycle pulse: restart at the frame base, flush partial data
//   pixel_data    64-bit pixel word (two 32-bit pixels, low pixel first)
//   pixel_valid   pixel_data is valid
//   pixel_ready   word accepted when pixel_valid && pixel_ready
//   address       Avalon word address (byte address >> 3)
//   burstcount    constant BURST
//   waitrequest   slave stall
//   write         write request
//   writedata     beat data (FIFO head)
//   byteenable    constant 8'hFF
//   busy          burst in progress or FIFO non-empty
//   debug_value0  completed bursts since reset
//   debug_value1  {frames started[15:0], words dropped[15:0]}
// -----------------------------------------------------------------------------
module frame_buffer_writer #(
    parameter logic [29:0] ADDRESS    = 30'h3800_0000,
    parameter int unsigned LENGTH     = 800 * 480 * 4,
    parameter int unsigned BURST      = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic [63:0] pixel_data,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    output logic [28:0] address,
    output logic [7:0]  burstcount,
    input  logic        waitrequest,
    output logic        write,
    output logic [63:0] writedata,
    output logic [7:0]  byteenable,
    output logic        busy,
    output logic [31:0] debug_value0,
    output logic [31:0] debug_value1
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [28:0]   BASE_WORD = 29'(ADDRESS >> 3);
    localparam logic [28:0]   END_WORD  = 29'((64'(ADDRESS) + 64'(LENGTH)) >> 3);
    localparam logic [28:0]   BURST_WORDS = 29'(BURST);
    localparam logic [CW-1:0] BURST_CNT = CW'(BURST);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(32'd1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(32'd1);
    localparam logic [7:0]    BEAT_LAST = 8'(BURST - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t        state_r;
    state_t        next_state_s;

    logic [63:0]   fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    logic          restart_pending_r;
    logic          write_r;
    logic [28:0]   ptr_r;
    logic [7:0]    beat_r;
    logic [31:0]   bursts_r;
    logic [15:0]   frames_r;
    logic [15:0]   dropped_r;

    logic          fifo_full_s;
    logic          ready_s;
    logic          push_s;
    logic          pop_s;
    logic          last_beat_s;
    logic [CW-1:0] count_avail_s;
    logic          start_burst_s;
    logic          end_burst_s;
    logic          flush_s;
    logic [28:0]   ptr_next_s;
    logic [16:0]   dropped_sum_s;
    logic [15:0]   dropped_next_s;

    // Stream handshake, FIFO push/pop qualifiers and the running word count.
    always_comb begin
        fifo_full_s   = (count_r == DEPTH_CNT);
        // Pushes are refused while a restart is requested or pending so the
        // flush never races a new word into the FIFO.
        ready_s       = !fifo_full_s && !frame_start && !restart_pending_r;
        push_s        = pixel_valid && ready_s;
        pop_s         = write_r && !waitrequest;
        last_beat_s   = pop_s && (beat_r == BEAT_LAST);
        // Including this cycle's push lets the burst start one cycle after the
        // BURST-th word is accepted.
        count_avail_s = count_r + (push_s ? CNT_ONE : {CW{1'b0}});
    end

    // Burst pointer advance with wrap at the frame end, and saturating drop count.
    always_comb begin
        ptr_next_s     = ptr_r + BURST_WORDS;
        if (ptr_next_s == END_WORD) begin
            ptr_next_s = BASE_WORD;
        end else begin
            ptr_next_s = ptr_r + BURST_WORDS;
        end
        dropped_sum_s  = {1'b0, dropped_r} + 17'(count_r);
        if (dropped_sum_s[16]) begin
            dropped_next_s = 16'hFFFF;
        end else begin
            dropped_next_s = dropped_sum_s[15:0];
        end
    end

    // Next-state logic and one-cycle control strobes for the datapath.
    always_comb begin
        next_state_s  = state_r;
        start_burst_s = 1'b0;
        end_burst_s   = 1'b0;
        flush_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (restart_pending_r) begin
                    flush_s      = 1'b1;
                    next_state_s = ST_IDLE;
                end else if (!frame_start && (count_avail_s >= BURST_CNT)) begin
                    start_burst_s = 1'b1;
                    next_state_s  = ST_BURST;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (last_beat_s) begin
                    end_burst_s  = 1'b1;
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_BURST;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FIFO storage; contents are meaningless until pointed at by the count.
    always_ff @(posedge clock) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= pixel_data;
        end
    end

    // FIFO pointers and occupancy; a flush discards everything unread.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush_s) begin
            rd_ptr_r <= wr_ptr_r;
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Burst master registers: write strobe, beat counter and frame pointer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            write_r <= 1'b0;
            beat_r  <= 8'd0;
            ptr_r   <= BASE_WORD;
        end else begin
            if (start_burst_s) begin
                write_r <= 1'b1;
                beat_r  <= 8'd0;
            end else if (end_burst_s) begin
                write_r <= 1'b0;
                beat_r  <= 8'd0;
            end else if (pop_s) begin
                beat_r  <= beat_r + 8'd1;
            end
            if (flush_s) begin
                ptr_r <= BASE_WORD;
            end else if (end_burst_s) begin
                ptr_r <= ptr_next_s;
            end
        end
    end

    // Restart request and statistics counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            restart_pending_r <= 1'b0;
            bursts_r          <= 32'd0;
            frames_r          <= 16'd0;
            dropped_r         <= 16'd0;
        end else begin
            // A new request outranks the clear so back-to-back pulses are not lost.
            if (frame_start) begin
                restart_pending_r <= 1'b1;
                frames_r          <= frames_r + 16'd1;
            end else if (flush_s) begin
                restart_pending_r <= 1'b0;
            end
            if (flush_s) begin
                dropped_r <= dropped_next_s;
            end
            if (end_burst_s) begin
                bursts_r <= bursts_r + 32'd1;
            end
        end
    end

    assign pixel_ready  = ready_s;
    assign address      = ptr_r;
    assign burstcount   = 8'(BURST);
    assign write        = write_r;
    assign writedata    = fifo_mem_r[rd_ptr_r];
    assign byteenable   = 8'hFF;
    assign busy         = (state_r == ST_BURST) || (count_r != {CW{1'b0}});
    assign debug_value0 = bursts_r;
    assign debug_value1 = {frames_r, dropped_r};

endmodule

// File: tb/tb_frame_buffer_writer.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for frame_buffer_writer. The design runs with a
// 128-byte frame (two 8-beat bursts) so that pointer wrap is reachable.
// Inputs change 1 ns after the rising edge; accepted beats are captured on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_frame_buffer_writer;

    localparam logic [28:0] BASE = 29'h0700_0000;
    localparam logic [28:0] NEXT = 29'h0700_0008;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        frame_start;
    logic [63:0] pixel_data;
    logic        pixel_valid;
    logic        pixel_ready;
    logic [28:0] address;
    logic [7:0]  burstcount;
    logic        waitrequest;
    logic        write;
    logic [63:0] writedata;
    logic [7:0]  byteenable;
    logic        busy;
    logic [31:0] debug_value0;
    logic [31:0] debug_value1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [28:0] mon_addr [$];
    logic [63:0] mon_data [$];
    int          mon_cyc  [$];

    frame_buffer_writer #(
        .ADDRESS    (30'h3800_0000),
        .LENGTH     (128),
        .BURST      (8),
        .FIFO_DEPTH (16)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .frame_start  (frame_start),
        .pixel_data   (pixel_data),
        .pixel_valid  (pixel_valid),
        .pixel_ready  (pixel_ready),
        .address      (address),
        .burstcount   (burstcount),
        .waitrequest  (waitrequest),
        .write        (write),
        .writedata    (writedata),
        .byteenable   (byteenable),
        .busy         (busy),
        .debug_value0 (debug_value0),
        .debug_value1 (debug_value1)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (reset_n && write && !waitrequest) begin
            mon_addr.push_back(address);
            mon_data.push_back(writedata);
            mon_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_word(input logic [63:0] d);
        int n;
        n = 0;
        pixel_valid = 1'b1;
        pixel_data  = d;
        #1;
        while (!pixel_ready && n < 300) begin
            tick();
            #1;
            n++;
        end
        if (n >= 300) chk("push_ready_timeout", 64'(pixel_ready), 64'd1);
        tick();
        pixel_valid = 1'b0;
    endtask

    task automatic mon_clear();
        mon_addr.delete();
        mon_data.delete();
        mon_cyc.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        frame_start = 1'b0;
        pixel_data  = 64'd0;
        pixel_valid = 1'b0;
        waitrequest = 1'b0;

        // Reset state
        #12;
        chk("rst_write",      64'(write),        64'd0);
        chk("rst_address",    64'(address),      64'(BASE));
        chk("rst_burstcount", 64'(burstcount),   64'd8);
        chk("rst_byteenable", 64'(byteenable),   64'hFF);
        chk("rst_ready",      64'(pixel_ready),  64'd1);
        chk("rst_busy",       64'(busy),         64'd0);
        chk("rst_dbg0",       64'(debug_value0), 64'd0);
        chk("rst_dbg1",       64'(debug_value1), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Single burst, no stall
        mon_clear();
        for (int i = 1; i <= 8; i++) push_word(64'(i));
        chk("b1_latency_write", 64'(write),     64'd1);
        chk("b1_first_data",    writedata,      64'd1);
        repeat (8) tick();
        chk("b1_write_done", 64'(write), 64'd0);
        chk("b1_beats", 64'(mon_data.size()), 64'd8);
        for (int i = 0; i < 8 && i < mon_data.size(); i++) begin
            chk($sformatf("b1_data%0d", i), mon_data[i], 64'(i + 1));
            chk($sformatf("b1_addr%0d", i), 64'(mon_addr[i]), 64'(BASE));
            chk($sformatf("b1_cyc%0d", i), 64'(mon_cyc[i] - mon_cyc[0]), 64'(i));
        end
        chk("b1_dbg0", 64'(debug_value0), 64'd1);
        chk("b1_busy", 64'(busy), 64'd0);

        // Burst with a three-cycle stall on beat 3
        mon_clear();
        for (int i = 1; i <= 8; i++) push_word(64'(i));
        tick();
        tick();
        waitrequest = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stall%0d_write", k), 64'(write), 64'd1);
            chk($sformatf("stall%0d_data", k),  writedata, 64'd3);
            chk($sformatf("stall%0d_addr", k),  64'(address), 64'(NEXT));
            tick();
        end
        waitrequest = 1'b0;
        repeat (10) tick();
        chk("b2_beats", 64'(mon_data.size()), 64'd8);
        for (int i = 0; i < 8 && i < mon_data.size(); i++) begin
            chk($sformatf("b2_data%0d", i), mon_data[i], 64'(i + 1));
            chk($sformatf("b2_addr%0d", i), 64'(mon_addr[i]), 64'(NEXT));
        end
        chk("b2_dbg0", 64'(debug_value0), 64'd2);

        // Three bursts across the frame wrap
        mon_clear();
        for (int i = 0; i < 24; i++) push_word(64'(32'h101 + i));
        repeat (20) tick();
        chk("w_beats", 64'(mon_data.size()), 64'd24);
        for (int i = 0; i < 24 && i < mon_data.size(); i++) begin
            chk($sformatf("w_data%0d", i), mon_data[i], 64'(32'h101 + i));
            chk($sformatf("w_addr%0d", i), 64'(mon_addr[i]), ((i / 8) == 1) ? 64'(NEXT) : 64'(BASE));
        end
        if (mon_cyc.size() == 24) begin
            chk("w_gap1", 64'(mon_cyc[8] - mon_cyc[7]), 64'd2);
            chk("w_gap2", 64'(mon_cyc[16] - mon_cyc[15]), 64'd2);
        end
        chk("w_dbg0",  64'(debug_value0), 64'd5);
        chk("w_write", 64'(write), 64'd0);
        chk("w_busy",  64'(busy), 64'd0);

        // Partial data dropped by frame_start
        mon_clear();
        for (int i = 0; i < 5; i++) push_word(64'(32'h201 + i));
        chk("fs_busy_partial", 64'(busy), 64'd1);
        chk("fs_no_write",     64'(write), 64'd0);
        frame_start = 1'b1;
        #1;
        chk("fs_ready_pulse", 64'(pixel_ready), 64'd0);
        tick();
        frame_start = 1'b0;
        #1;
        chk("fs_ready_pending", 64'(pixel_ready), 64'd0);
        tick();
        chk("fs_ready_after", 64'(pixel_ready),  64'd1);
        chk("fs_busy_after",  64'(busy),         64'd0);
        chk("fs_dbg1",        64'(debug_value1), 64'h0001_0005);
        chk("fs_address",     64'(address),      64'(BASE));
        repeat (3) tick();
        chk("fs_no_beats", 64'(mon_data.size()), 64'd0);
        for (int i = 0; i < 8; i++) push_word(64'(32'h301 + i));
        repeat (10) tick();
        chk("fs_beats", 64'(mon_data.size()), 64'd8);
        for (int i = 0; i < 8 && i < mon_data.size(); i++) begin
            chk($sformatf("fs_data%0d", i), mon_data[i], 64'(32'h301 + i));
            chk($sformatf("fs_addr%0d", i), 64'(mon_addr[i]), 64'(BASE));
        end
        chk("fs_dbg0", 64'(debug_value0), 64'd6);

        // Backpressure: FIFO fills to 16, then drains in order
        mon_clear();
        waitrequest = 1'b1;
        for (int i = 0; i < 16; i++) push_word(64'(32'h401 + i));
        pixel_valid = 1'b1;
        pixel_data  = 64'h411;
        #1;
        chk("bp_ready_full", 64'(pixel_ready), 64'd0);
        repeat (3) tick();
        chk("bp_ready_held", 64'(pixel_ready), 64'd0);
        chk("bp_write",      64'(write),       64'd1);
        chk("bp_addr",       64'(address),     64'(NEXT));
        chk("bp_data",       writedata,        64'h401);
        waitrequest = 1'b0;
        for (int i = 16; i < 20; i++) push_word(64'(32'h401 + i));
        repeat (30) tick();
        chk("bp_beats", 64'(mon_data.size()), 64'd16);
        for (int i = 0; i < 16 && i < mon_data.size(); i++) begin
            chk($sformatf("bp_data%0d", i), mon_data[i], 64'(32'h401 + i));
            chk($sformatf("bp_addr%0d", i), 64'(mon_addr[i]), (i < 8) ? 64'(NEXT) : 64'(BASE));
        end
        chk("bp_dbg0",  64'(debug_value0), 64'd8);
        chk("bp_write_idle", 64'(write), 64'd0);
        chk("bp_busy_left",  64'(busy),  64'd1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        chk("bp_dbg1", 64'(debug_value1), 64'h0002_0009);
        chk("bp_busy_flushed", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of a burst
        mon_clear();
        for (int i = 0; i < 8; i++) push_word(64'(32'h501 + i));
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_write",   64'(write),        64'd0);
        chk("ar_dbg0",    64'(debug_value0), 64'd0);
        chk("ar_dbg1",    64'(debug_value1), 64'd0);
        chk("ar_busy",    64'(busy),         64'd0);
        chk("ar_address", 64'(address),      64'(BASE));
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        chk("ar_write_after", 64'(write),           64'd0);
        chk("ar_ready_after", 64'(pixel_ready),     64'd1);
        chk("ar_beats",       64'(mon_data.size()), 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_buffer_writer.md
# frame_buffer_writer

Avalon-MM burst write master that streams pixel words into the HPS SDRAM frame buffer through the f2h_sdram0 port. It is the producer counterpart of the frame buffer reader that scans the same region out to the LCD. A drawing engine, or the HPS via a bridge, pushes 64-bit pixel words over a valid/ready stream. The block packs them into fixed-length bursts and writes them sequentially from the frame base, wrapping at the frame end.

## Interface
Parameters:
- ADDRESS, 30'h3800_0000: frame base, byte address; must be 8×BURST-byte aligned.
- LENGTH, 800*480*4: frame size in bytes; must be a multiple of 8×BURST.
- BURST, 8: beats (64-bit words) per burst, 1..128.
- FIFO_DEPTH, 16: input FIFO words; power of two, ≥ BURST.

Ports:
- clock  in  1  system clock (clock_50 domain). One clock; reset is asynchronous and active-low.
- reset_n  in  1  async active-low reset.
- frame_start  in  1  one-cycle pulse: restart at ADDRESS, flush partial data.
- pixel_data  in  64  pixel word, two 32-bit pixels, low pixel first.
- pixel_valid  in  1  pixel_data valid.
- pixel_ready  out  1  word accepted when valid && ready.
- address  out  29  Avalon word address (byte address >> 3).
- burstcount  out  8  constant BURST.
- waitrequest  in  1  slave stall.
- write  out  1  write request.
- writedata  out  64  beat data.
- byteenable  out  8  constant 8'hFF.
- busy  out  1  burst in progress or FIFO non-empty.
- debug_value0  out  32  completed bursts since reset.
- debug_value1  out  32  {frames started[15:0], words dropped[15:0]}.

## Operation
- Input FIFO: write on pixel_valid && pixel_ready; pixel_ready = !fifo_full && !frame_start && !restart_pending (combinational).
- States: IDLE, BURST.
  - IDLE: restart_pending set → flush FIFO, add FIFO count to dropped counter (saturating at 16'hFFFF), pointer = ADDRESS>>3, clear restart_pending, stay IDLE. Otherwise, if FIFO count ≥ BURST → BURST, write=1, address=pointer.
  - BURST: each cycle write && !waitrequest consumes one beat (FIFO pop). On the last beat: write=0, pointer += BURST; if pointer reaches (ADDRESS+LENGTH)>>3, pointer = ADDRESS>>3; debug_value0++; → IDLE.
- address, burstcount and byteenable are held constant for the whole burst. writedata = FIFO head, which advances only on an accepted beat.
- frame_start: sets restart_pending and increments the frame counter (wraps). In IDLE, the flush happens on the next cycle. In BURST, the current burst completes normally, then the flush runs. A frame_start while restart_pending is already set increments the frame counter only.
- Words fewer than BURST never issue a burst; they wait or are dropped by frame_start.
- Counters wrap at 2^32 (bursts) and 2^16 (frames).

## Timing
- Reset values: write 0, pixel_ready 1, address ADDRESS>>3, burstcount BURST, byteenable 8'hFF, busy 0, debug counters 0, state IDLE. writedata is don't-care whenever write=0.
- Reset asserted mid-burst: write drops immediately (async) and FIFO contents are lost.
- Latency: the BURST-th word is accepted at cycle N → write=1 at N+1. With waitrequest low, beats occur at N+1..N+BURST.
- Between bursts, write is low for exactly one cycle (the IDLE cycle) before the next burst.
- Under waitrequest=1, write, address and writedata stay stable until the beat is accepted.
- Sustained throughput: BURST words per BURST+1 cycles.
- A FIFO push and pop in the same cycle leaves the count unchanged. The full flag blocks pushes even if a pop occurs that cycle.

## Test plan
- Reset → write 0, address 29'h0700_0000, byteenable 8'hFF, pixel_ready 1, debug values 0.
- Push 8 words 0x1..0x8, waitrequest 0 → write high for 8 consecutive cycles at 29'h0700_0000, burstcount 8, data 0x1..0x8 in order, debug_value0 = 1.
- Same stream with waitrequest high 3 cycles during beat 3 → beat 3 data 0x3 and address held; 8 beats total; no duplicated or skipped data.
- LENGTH=128 (2 bursts), push 24 words → bursts at 0x0700_0000, 0x0700_0008, then 0x0700_0000 again.
- Push 5 words, pulse frame_start → no write; dropped = 5, frames = 1; the next 8 words write at 0x0700_0000.
- waitrequest held 1, push 20 words → pixel_ready low after 16 accepted; after release, all 16 drain in order and the remaining 4 are then accepted.
